// File: rtl/regfile_wb_arbiter_pkg.sv
// rf_pkg: shared register-file write-back widths, zero-register index and request type
package rf_pkg;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ZERO_REG = 0;
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request at or after ptr wins
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] j;
    // walk from farthest to nearest so the nearest requester after ptr overwrites the rest
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back port sharing with registered output stage; RF_WB_BYPASS_EN adds decode forwarding
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int ADDR_W = RF_ADDR_W,
    parameter  int DATA_W = RF_DATA_W,
    parameter  int CNT_W  = 16,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    regWrite,
    output logic [ADDR_W-1:0]       writeReg,
    output logic [DATA_W-1:0]       writeData,
    output logic [IW-1:0]           grant_id,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0]       rd_addr1,
    input  logic [ADDR_W-1:0]       rd_addr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic [DATA_W-1:0]       fwd_data2,
`endif
    output logic [CNT_W-1:0]        wr_count
);
    logic [IW-1:0]     rrPtr;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gntIdx;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic              handshake;
    logic              isWrite;

    rr_arbiter #(.N(N_REQ)) uArb (
        .req     (req_valid),
        .ptr     (rrPtr),
        .gnt     (gnt),
        .gnt_idx (gntIdx)
    );

    assign req_ready = rst_n ? gnt : '0;
    assign handshake = |req_ready;
    assign selAddr   = req_addr[int'(gntIdx)*ADDR_W +: ADDR_W];
    assign selData   = req_data[int'(gntIdx)*DATA_W +: DATA_W];
    assign isWrite   = handshake && selAddr != ADDR_W'(RF_ZERO_REG);

    // output stage, pointer and commit counter; x0 grants load the stage but never write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            grant_id  <= '0;
            wr_count  <= '0;
            rrPtr     <= '0;
        end else begin
            regWrite <= isWrite;
            if (isWrite && wr_count != '1)
                wr_count <= wr_count + 1'b1;
            if (handshake) begin
                writeReg  <= selAddr;
                writeData <= selData;
                grant_id  <= gntIdx;
                rrPtr     <= gntIdx == IW'(N_REQ - 1) ? '0 : gntIdx + 1'b1;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign fwd_hit1  = regWrite && writeReg == rd_addr1 && rd_addr1 != ADDR_W'(RF_ZERO_REG);
    assign fwd_hit2  = regWrite && writeReg == rd_addr2 && rd_addr2 != ADDR_W'(RF_ZERO_REG);
    assign fwd_data1 = fwd_hit1 ? writeData : '0;
    assign fwd_data2 = fwd_hit2 ? writeData : '0;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : gStable
        assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[i] && !req_ready[i] |=> req_valid[i]
                && $stable(req_addr[i*ADDR_W +: ADDR_W])
                && $stable(req_data[i*DATA_W +: DATA_W]));
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks against a queue-level write-back model
module tb_regfile_wb_arbiter;
    localparam int NR = 2, AW = 5, DW = 32, CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, rst_n = 0;
    logic [NR-1:0] req_valid, req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic [$clog2(NR)-1:0] grant_id;
    logic [CW-1:0] wr_count;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] rd_addr1 = 0, rd_addr2 = 0;
    logic fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
`endif

    regfile_wb_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .grant_id(grant_id),
`ifdef RF_WB_BYPASS_EN
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic vld[NR];
    logic [AW-1:0] adr[NR];
    logic [DW-1:0] dat[NR];
    int mPtr, mGid, mCnt, lastW;
    logic mWe;
    logic [AW-1:0] mReg;
    logic [DW-1:0] mData;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < NR; k++) begin
            req_valid[k] = vld[k];
            req_addr[k*AW +: AW] = adr[k];
            req_data[k*DW +: DW] = dat[k];
        end
    endtask

    task automatic modelReset();
        mPtr = 0; mGid = 0; mCnt = 0; mWe = 0; mReg = 0; mData = 0;
    endtask

    task automatic checkOut();
        check("regWrite", regWrite, mWe);
        check("writeReg", writeReg, mReg);
        check("writeData", writeData, mData);
        check("grant_id", grant_id, mGid);
        check("wr_count", wr_count, mCnt);
    endtask

    // one clock: pick the first valid requester from the pointer, then predict the output stage
    task automatic cycle();
        int w = -1;
        apply();
        for (int k = 0; k < NR; k++)
            if (w < 0 && vld[(mPtr + k) % NR]) w = (mPtr + k) % NR;
        #1 check("req_ready", req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
        @(posedge clk);
        lastW = w;
        if (w >= 0) begin
            mGid = w; mReg = adr[w]; mData = dat[w]; mWe = adr[w] != 0;
            if (mWe && mCnt < CMAX) mCnt++;
            mPtr = (w + 1) % NR;
        end else mWe = 0;
        #1 checkOut();
    endtask

    task automatic drain();
        repeat (NR) begin
            cycle();
            if (lastW >= 0) vld[lastW] = 0;
        end
    endtask

    initial begin
        #100000 $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NR; k++) begin vld[k] = 1; adr[k] = 0; dat[k] = 0; end
        apply();
        modelReset();
        #2;
        check("rst_ready", req_ready, 0);
        checkOut();
        @(posedge clk); #1;
        check("rst_ready_edge", req_ready, 0);
        check("rst_regWrite_edge", regWrite, 0);
        adr[0] = 3; dat[0] = 32'hAAAA_0001;
        adr[1] = 4; dat[1] = 32'hBBBB_0002;
        rst_n = 1;
        cycle();
        check("first_grant", grant_id, 0);
        repeat (3) cycle();
        check("wr_count_4", wr_count, 4);
        vld[1] = 0;
        drain();
        vld[1] = 1; adr[1] = 7; dat[1] = 32'h1234_5678;
        cycle();
        check("single_gid", grant_id, 1);
        vld[1] = 0;
        cycle();
        vld[0] = 1; adr[0] = 0; dat[0] = 32'hDEAD_BEEF;
        cycle();
        check("x0_noWrite", regWrite, 0);
        vld[0] = 1; adr[0] = 10; dat[0] = 1;
        vld[1] = 1; adr[1] = 11; dat[1] = 2;
        cycle();
        check("x0_ptr_adv", lastW, 1);
        vld[lastW] = 0;
        drain();
        vld[0] = 1; adr[0] = 9; dat[0] = 32'h9999;
        apply();
        #1 check("pre_rst_ready", req_ready, 1);
        #1 rst_n = 0;
        #1;
        check("async_ready", req_ready, 0);
        check("async_regWrite", regWrite, 0);
        check("async_writeReg", writeReg, 0);
        check("async_writeData", writeData, 0);
        check("async_count", wr_count, 0);
        vld[0] = 0;
        apply();
        @(posedge clk); #1 check("no_addr9", regWrite, 0);
        @(posedge clk); #1 rst_n = 1;
        modelReset();
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < NR; j++)
                if (!vld[j] && $urandom_range(0, 2) != 0) begin
                    vld[j] = 1;
                    adr[j] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 7));
                    dat[j] = $urandom;
                end
            cycle();
            if (lastW >= 0) vld[lastW] = 0;
        end
        check("saturated", wr_count, CMAX);
        drain();
`ifdef RF_WB_BYPASS_EN
        vld[0] = 1; adr[0] = 5; dat[0] = 32'hCAFE_F00D;
        cycle();
        vld[0] = 0;
        rd_addr1 = 5; rd_addr2 = 0;
        #1;
        check("fwd_hit1", fwd_hit1, 1);
        check("fwd_data1", fwd_data1, 32'hCAFE_F00D);
        check("fwd_hit2", fwd_hit2, 0);
        check("fwd_data2", fwd_data2, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between N_REQ write-back requesters, e.g. the ALU and the load unit. Arbitration is round-robin with a valid/ready handshake. The block drives regWrite/writeReg/writeData through a one-entry registered output stage. It suppresses architectural writes to x0 and counts committed writes.

Parameters:
N_REQ, 2, number of write-back requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width
CNT_W, 16, width of committed-write counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester write request valid
req_addr  input  N_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  packed write data, same packing
req_ready  output  N_REQ  one-hot grant, combinational; handshake completes when valid&ready
regWrite  output  1  registered write enable to register file
writeReg  output  ADDR_W  registered write address
writeData  output  DATA_W  registered write data
grant_id  output  $clog2(N_REQ)  index of requester whose write is in the output stage
wr_count  output  CNT_W  saturating count of committed (non-x0) writes

Behaviour:
- Reset (async, rst_n=0): regWrite=0, writeReg=0, writeData=0, grant_id=0, wr_count=0, rr pointer=0. An in-flight output-stage write is discarded. req_ready=0 while rst_n=0.
- Arbitration:
  - Each cycle, search req_valid starting at rr pointer, wrapping modulo N_REQ. The first set bit wins.
  - req_ready is one-hot on the winner. It is all-zero when no valid is set.
  - At most one handshake per cycle.
- Pointer update: on a handshake by requester g, rr pointer <= (g+1) mod N_REQ. No handshake leaves the pointer unchanged.
- Latency: a handshake in cycle t produces regWrite/writeReg/writeData/grant_id valid in cycle t+1, held for exactly one cycle. Sustained throughput is one write per cycle. The register file is never back-pressured.
- No handshake in cycle t: regWrite=0 in t+1. writeReg/writeData/grant_id hold their previous values.
- x0 rule: a request with addr==0 is granted and consumes its arbitration slot and pointer advance. regWrite stays 0 in t+1, and wr_count does not increment.
- wr_count increments by 1 in the same edge that sets regWrite=1. It saturates at 2^CNT_W-1.
- Requester rules: once req_valid is high, req_valid/addr/data must stay stable until req_ready. An assertion checks this in simulation.
- Simultaneous requests to the same address from different requesters are written in grant order. The later grant wins in the register file.
- Reset deasserted mid-stream: arbitration restarts from requester 0 on the first post-reset edge.

Optional Feature:
Macro RF_WB_BYPASS_EN.
- Defined: adds inputs rd_addr1/rd_addr2 (ADDR_W) and outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DATA_W).
  - fwd_hitK = regWrite & (writeReg==rd_addrK) & (rd_addrK!=0), combinational.
  - fwd_dataK = writeData when hit, else 0.
  - These let the decode stage bypass the same-cycle register-file write.
- Undefined: the ports do not exist. There is no forwarding logic, and hazards are left to the pipeline stall logic.

Decomposition:
- Package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_REG=0, and a typedef for the write-request struct {addr, data}.
- Sub-module rr_arbiter: parameter N, inputs req[N] and ptr; output one-hot gnt and encoded gnt_idx. It is purely combinational. Pointer state stays in regfile_wb_arbiter.

Test Plan:
1. Reset with valid held high: rst_n=0 with req_valid=2'b11 -> req_ready=0, regWrite=0, wr_count=0. First edge after release grants requester 0.
2. Both requesters continuously valid (addr 3/data 0xAAAA_0001 and addr 4/data 0xBBBB_0002) -> grants alternate 0,1,0,1. regWrite=1 every cycle from cycle 2. writeReg alternates 3,4. wr_count=4 after 4 writes.
3. Single requester 1 valid, addr 7, data 0x1234_5678 -> req_ready=2'b10 same cycle. Next cycle regWrite=1, writeReg=7, writeData=0x1234_5678, grant_id=1. The following cycle regWrite=0.
4. Requester 0 writes addr 0, data 0xDEAD_BEEF -> handshake occurs, regWrite stays 0, wr_count unchanged, pointer advances to 1.
5. Reset asserted on the edge after a handshake to addr 9 -> regWrite never asserts for addr 9. All outputs are 0 asynchronously.
6. (RF_WB_BYPASS_EN) Output stage holds addr 5 / 0xCAFE_F00D with rd_addr1=5 and rd_addr2=0 -> fwd_hit1=1, fwd_data1=0xCAFE_F00D, fwd_hit2=0.
